// File: rtl/anton_neopixel_frame_scheduler_pkg.sv
// Shared definitions for the neopixel frame scheduler: default widths and FSM state encoding.
package anton_neopixel_frame_scheduler_pkg;

  localparam int unsigned DEF_PERIOD_WIDTH = 24;
  localparam int unsigned DEF_BUSY_TIMEOUT = 64;
  localparam int unsigned DEF_FCOUNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_ARM    = 3'd2,
    ST_STREAM = 3'd3,
    ST_SWAP   = 3'd4,
    ST_WAIT   = 3'd5
  } sched_state_e;

endpackage

// File: rtl/anton_neopixel_period_timer.sv
// Saturating frame-period counter. A load forces the count to 1; elapsed is registered and
// reflects count >= period, using the period value presented one cycle earlier.
module anton_neopixel_period_timer #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] period,
  output logic             elapsed
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             elapsed_q, elapsed_d;

  // Next count and elapsed flag; period 0 never elapses.
  always_comb begin
    count_d   = count_q;
    elapsed_d = 1'b0;
    if (load) begin
      count_d = WIDTH'(1);
    end else if (run && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
    elapsed_d = (period != '0) && (count_d >= period);
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      elapsed_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      elapsed_q <= elapsed_d;
    end
  end

  assign elapsed = elapsed_q;

endmodule

// File: rtl/anton_neopixel_frame_scheduler.sv
// Frame scheduler for the neopixel stream engine: issues syncStart on period or trigger, follows
// streamBusy, and swaps display buffers only at frame boundaries. swapAck and the bufferSel
// toggle become visible in the cycle after the SWAP state, so a request seen during SWAP is honoured.
module anton_neopixel_frame_scheduler
  import anton_neopixel_frame_scheduler_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int unsigned FCOUNT_WIDTH = DEF_FCOUNT_WIDTH
) (
  input  logic                    clk6_4mhz,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    softTrigger,
  input  logic                    swapRequest,
  input  logic                    flagClear,
  input  logic                    streamBusy,
  output logic                    syncStart,
  output logic                    bufferSel,
  output logic                    swapAck,
  output logic [FCOUNT_WIDTH-1:0] frameCount,
  output logic                    overrun,
  output logic                    startFault,
  output logic                    schedBusy
);

  localparam int unsigned         TO_WIDTH = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(BUSY_TIMEOUT - 1);

  sched_state_e            state_q, state_d;
  logic                    sync_start_q, sync_start_d;
  logic                    buffer_sel_q, buffer_sel_d;
  logic                    swap_ack_q, swap_ack_d;
  logic [FCOUNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                    overrun_q, overrun_d;
  logic                    start_fault_q, start_fault_d;
  logic                    sched_busy_q, sched_busy_d;
  logic                    pending_q, pending_d;
  logic [TO_WIDTH-1:0]     timeout_q, timeout_d;
  logic                    elapsed;
  logic                    enter_start;
  logic                    swap_now;
  logic                    fault_set;
  logic                    overrun_set;

  anton_neopixel_period_timer #(
    .WIDTH (PERIOD_WIDTH)
  ) u_period_timer (
    .clk     (clk6_4mhz),
    .rst     (reset),
    .load    (enter_start),
    .run     (state_q != ST_IDLE),
    .period  (period),
    .elapsed (elapsed)
  );

  // Next state, registered outputs, swap bookkeeping and sticky flags.
  always_comb begin
    state_d       = state_q;
    timeout_d     = timeout_q;
    enter_start   = 1'b0;
    swap_now      = 1'b0;
    fault_set     = 1'b0;
    overrun_set   = 1'b0;

    case (state_q)
      ST_IDLE:   if (enable && ((period != '0) || softTrigger)) state_d = ST_START;
      ST_START:  state_d = ST_ARM;
      ST_ARM: begin
        if (streamBusy) begin
          state_d = ST_STREAM;
        end else if (timeout_q >= TO_LAST) begin
          state_d   = ST_SWAP;
          fault_set = 1'b1;
        end
      end
      ST_STREAM: if (!streamBusy) state_d = ST_SWAP;
      ST_SWAP:   state_d = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (softTrigger || elapsed) begin
          state_d = ST_START;
        end
      end
      default:   state_d = ST_IDLE;
    endcase

    enter_start = (state_d == ST_START);
    overrun_set = elapsed && ((state_q == ST_ARM) || (state_q == ST_STREAM));
    swap_now    = (state_q == ST_SWAP) && (pending_q || swapRequest);

    // Timeout counts cycles since syncStart while waiting for the engine to respond.
    if (enter_start) begin
      timeout_d = '0;
    end else if (((state_q == ST_START) || (state_q == ST_ARM)) && (timeout_q != '1)) begin
      timeout_d = timeout_q + TO_WIDTH'(1);
    end

    sync_start_d  = enter_start;
    frame_count_d = enter_start ? (frame_count_q + FCOUNT_WIDTH'(1)) : frame_count_q;
    sched_busy_d  = (state_d != ST_IDLE);
    swap_ack_d    = swap_now;
    buffer_sel_d  = buffer_sel_q ^ swap_now;
    pending_d     = swap_now ? 1'b0 : (pending_q || swapRequest);

    // Sticky flags: a set event beats a same-cycle clear.
    overrun_d     = overrun_set ? 1'b1 : (flagClear ? 1'b0 : overrun_q);
    start_fault_d = fault_set   ? 1'b1 : (flagClear ? 1'b0 : start_fault_q);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk6_4mhz or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sync_start_q  <= 1'b0;
      buffer_sel_q  <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      start_fault_q <= 1'b0;
      sched_busy_q  <= 1'b0;
      pending_q     <= 1'b0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      sync_start_q  <= sync_start_d;
      buffer_sel_q  <= buffer_sel_d;
      swap_ack_q    <= swap_ack_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      start_fault_q <= start_fault_d;
      sched_busy_q  <= sched_busy_d;
      pending_q     <= pending_d;
      timeout_q     <= timeout_d;
    end
  end

  assign syncStart  = sync_start_q;
  assign bufferSel  = buffer_sel_q;
  assign swapAck    = swap_ack_q;
  assign frameCount = frame_count_q;
  assign overrun    = overrun_q;
  assign startFault = start_fault_q;
  assign schedBusy  = sched_busy_q;

endmodule

// File: tb/tb_anton_neopixel_frame_scheduler.sv
// Bench for the neopixel frame scheduler: a stream-engine model drives streamBusy after each
// syncStart, and per-frame expectations come from frame-level timing rules.
`timescale 1ns/1ps
module tb_anton_neopixel_frame_scheduler;

  localparam int unsigned PW = 24;
  localparam int unsigned FW = 16;

  logic          clk6_4mhz = 1'b0;
  logic          reset, enable, softTrigger, swapRequest, flagClear, streamBusy;
  logic [PW-1:0] period;
  logic          syncStart, bufferSel, swapAck, overrun, startFault, schedBusy;
  logic [FW-1:0] frameCount;

  int vectors = 0;
  int miscompares = 0;

  // Cycle bookkeeping and stream-engine model state.
  int cyc = 0;
  int busy_from = 0, busy_to = 0, eng_delay = 2, eng_len = 40;
  bit eng_stuck = 1'b0;
  int last_sync = -1, sync_cnt = 0, ack_cnt = 0, last_ack = -1, bsel_violations = 0;
  int req_a = -1, req_b = -1, trig_at = -1;
  logic prev_busy = 1'b0, prev_bsel = 1'b0;

  anton_neopixel_frame_scheduler dut (
    .clk6_4mhz   (clk6_4mhz),
    .reset       (reset),
    .enable      (enable),
    .period      (period),
    .softTrigger (softTrigger),
    .swapRequest (swapRequest),
    .flagClear   (flagClear),
    .streamBusy  (streamBusy),
    .syncStart   (syncStart),
    .bufferSel   (bufferSel),
    .swapAck     (swapAck),
    .frameCount  (frameCount),
    .overrun     (overrun),
    .startFault  (startFault),
    .schedBusy   (schedBusy)
  );

  always #5 clk6_4mhz = ~clk6_4mhz;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // One clock: observe outputs just after the edge, then drive inputs for the new cycle.
  task automatic tick();
    @(posedge clk6_4mhz);
    #1;
    cyc++;
    if ((bufferSel !== prev_bsel) && prev_busy) bsel_violations++;
    prev_bsel = bufferSel;
    if (swapAck === 1'b1) begin
      ack_cnt++;
      last_ack = cyc;
    end
    if (syncStart === 1'b1) begin
      last_sync = cyc;
      sync_cnt++;
      if (!eng_stuck) begin
        busy_from = cyc + eng_delay;
        busy_to   = busy_from + eng_len;
      end
    end
    streamBusy  = (cyc >= busy_from) && (cyc < busy_to);
    prev_busy   = streamBusy;
    swapRequest = (cyc == req_a) || (cyc == req_b);
    softTrigger = (cyc == trig_at);
  endtask

  task automatic tick_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_sync(input int budget, output bit ok);
    int n0;
    n0 = sync_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sync_cnt != n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; period = '0; flagClear = 1'b0;
    req_a = -1; req_b = -1; trig_at = -1; eng_stuck = 1'b0;
    busy_from = 0; busy_to = 0; streamBusy = 1'b0; swapRequest = 1'b0; softTrigger = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    prev_bsel = 1'b0; prev_busy = 1'b0; ack_cnt = 0; sync_cnt = 0; bsel_violations = 0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; period = '0; softTrigger = 1'b0; swapRequest = 1'b0;
    flagClear = 1'b0; streamBusy = 1'b0;
    #2;
    vectors++; if (syncStart !== 1'b0) begin miscompares++; $display("FAIL reset_syncStart got %0b want 0", syncStart); end
    vectors++; if (bufferSel !== 1'b0) begin miscompares++; $display("FAIL reset_bufferSel got %0b want 0", bufferSel); end
    vectors++; if (swapAck !== 1'b0) begin miscompares++; $display("FAIL reset_swapAck got %0b want 0", swapAck); end
    vectors++; if (frameCount !== 16'd0) begin miscompares++; $display("FAIL reset_frameCount got %0d want 0", frameCount); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %0b want 0", overrun); end
    vectors++; if (startFault !== 1'b0) begin miscompares++; $display("FAIL reset_startFault got %0b want 0", startFault); end
    vectors++; if (schedBusy !== 1'b0) begin miscompares++; $display("FAIL reset_schedBusy got %0b want 0", schedBusy); end
    do_reset();
    repeat (5) tick();
    vectors++; if (schedBusy !== 1'b0 || sync_cnt != 0) begin miscompares++; $display("FAIL idle_disabled busy=%0b syncs=%0d want 0/0", schedBusy, sync_cnt); end
  endtask

  task automatic test_periodic();
    bit ok;
    int t0, s;
    do_reset();
    period = PW'(100); eng_delay = 2; eng_len = 38; enable = 1'b1; t0 = cyc;
    wait_sync(10, ok);
    vectors++; if (!ok || last_sync != t0 + 1) begin miscompares++; $display("FAIL periodic_first_sync at %0d want %0d", last_sync, t0 + 1); end
    vectors++; if (frameCount !== 16'd1) begin miscompares++; $display("FAIL periodic_fc1 got %0d want 1", frameCount); end
    s = last_sync;
    for (int k = 2; k <= 4; k++) begin
      wait_sync(150, ok);
      vectors++; if (!ok || (last_sync - s) != 100) begin miscompares++; $display("FAIL periodic_gap got %0d want 100", last_sync - s); end
      vectors++; if (frameCount !== FW'(k)) begin miscompares++; $display("FAIL periodic_fc got %0d want %0d", frameCount, k); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL periodic_overrun got %0b want 0", overrun); end
      s = last_sync;
    end
    tick();
    vectors++; if (syncStart !== 1'b0) begin miscompares++; $display("FAIL periodic_pulse_width got %0b want 0", syncStart); end
  endtask

  task automatic test_overrun();
    bit ok;
    int s, f;
    do_reset();
    period = PW'(100); eng_delay = 2; eng_len = 150; enable = 1'b1;
    wait_sync(10, ok);
    f = busy_to;
    wait_sync(300, ok);
    vectors++; if (!ok || last_sync != f + 3) begin miscompares++; $display("FAIL overrun_restart at %0d want %0d", last_sync, f + 3); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set got %0b want 1", overrun); end
    s = last_sync; f = busy_to;
    flagClear = 1'b1; tick(); flagClear = 1'b0;
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_clear got %0b want 0", overrun); end
    tick_until(s + 99);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_early got %0b want 0", overrun); end
    tick();
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_reset_at_period got %0b want 1", overrun); end
    wait_sync(300, ok);
    vectors++; if (!ok || last_sync != f + 3) begin miscompares++; $display("FAIL overrun_restart2 at %0d want %0d", last_sync, f + 3); end
  endtask

  task automatic test_swap();
    bit ok;
    int s, f;
    do_reset();
    period = PW'(100); eng_delay = 2; eng_len = 40; enable = 1'b1;
    wait_sync(10, ok);
    s = last_sync; f = busy_to; req_a = s + 10; ack_cnt = 0;
    wait_sync(150, ok);
    vectors++; if (ack_cnt != 1 || last_ack != f + 2) begin miscompares++; $display("FAIL swap_single acks=%0d at %0d want 1 at %0d", ack_cnt, last_ack, f + 2); end
    vectors++; if (bufferSel !== 1'b1) begin miscompares++; $display("FAIL swap_single_sel got %0b want 1", bufferSel); end
    s = last_sync; req_a = s + 5; req_b = s + 20; ack_cnt = 0;
    wait_sync(150, ok);
    vectors++; if (ack_cnt != 1 || bufferSel !== 1'b0) begin miscompares++; $display("FAIL swap_collapse acks=%0d sel=%0b want 1/0", ack_cnt, bufferSel); end
    f = busy_to; req_a = f + 1; req_b = -1; ack_cnt = 0;
    wait_sync(150, ok);
    vectors++; if (ack_cnt != 1 || last_ack != f + 2 || bufferSel !== 1'b1) begin miscompares++; $display("FAIL swap_in_swap_cycle acks=%0d at %0d sel=%0b want 1 at %0d sel 1", ack_cnt, last_ack, bufferSel, f + 2); end
    ack_cnt = 0;
    wait_sync(150, ok);
    vectors++; if (ack_cnt != 0 || bufferSel !== 1'b1) begin miscompares++; $display("FAIL swap_none acks=%0d sel=%0b want 0/1", ack_cnt, bufferSel); end
    vectors++; if (bsel_violations != 0) begin miscompares++; $display("FAIL swap_while_busy count=%0d want 0", bsel_violations); end
  endtask

  task automatic test_oneshot();
    bit ok;
    int t, s;
    do_reset();
    period = '0; eng_delay = 2; eng_len = 40; enable = 1'b1;
    repeat (20) tick();
    vectors++; if (sync_cnt != 0 || schedBusy !== 1'b0) begin miscompares++; $display("FAIL oneshot_idle syncs=%0d busy=%0b want 0/0", sync_cnt, schedBusy); end
    t = cyc + 5;
    for (int k = 1; k <= 3; k++) begin
      trig_at = t;
      wait_sync(t - cyc + 10, ok);
      vectors++; if (!ok || last_sync != t + 1) begin miscompares++; $display("FAIL oneshot_sync at %0d want %0d", last_sync, t + 1); end
      s = last_sync;
      trig_at = s + 20;
      tick_until(t + 199);
      vectors++; if (sync_cnt != k || schedBusy !== 1'b1) begin miscompares++; $display("FAIL oneshot_ignored syncs=%0d busy=%0b want %0d/1", sync_cnt, schedBusy, k); end
      t = t + 200;
    end
    vectors++; if (frameCount !== 16'd3) begin miscompares++; $display("FAIL oneshot_fc got %0d want 3", frameCount); end
  endtask

  task automatic test_start_fault();
    bit ok;
    int s;
    do_reset();
    period = '0; eng_stuck = 1'b1; enable = 1'b1; trig_at = cyc + 2;
    wait_sync(10, ok);
    s = last_sync;
    tick_until(s + 63);
    vectors++; if (startFault !== 1'b0) begin miscompares++; $display("FAIL fault_early got %0b want 0", startFault); end
    tick();
    vectors++; if (startFault !== 1'b1) begin miscompares++; $display("FAIL fault_set got %0b want 1", startFault); end
    tick_until(s + 70);
    vectors++; if (schedBusy !== 1'b1 || sync_cnt != 1) begin miscompares++; $display("FAIL fault_to_wait busy=%0b syncs=%0d want 1/1", schedBusy, sync_cnt); end
    flagClear = 1'b1; tick(); flagClear = 1'b0;
    vectors++; if (startFault !== 1'b0) begin miscompares++; $display("FAIL fault_clear got %0b want 0", startFault); end
    eng_stuck = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int s;
    do_reset();
    period = PW'(100); eng_delay = 2; eng_len = 60; enable = 1'b1;
    wait_sync(10, ok);
    s = last_sync; req_a = s + 10;
    tick_until(s + 20);
    #3 reset = 1'b1;
    #1;
    vectors++; if ({syncStart, bufferSel, swapAck, overrun, startFault, schedBusy} !== 6'b0) begin miscompares++; $display("FAIL async_reset_flags got %b want 000000", {syncStart, bufferSel, swapAck, overrun, startFault, schedBusy}); end
    vectors++; if (frameCount !== 16'd0) begin miscompares++; $display("FAIL async_reset_fc got %0d want 0", frameCount); end
    busy_from = 0; busy_to = 0; streamBusy = 1'b0;
    repeat (2) tick();
    reset = 1'b0; ack_cnt = 0;
    wait_sync(10, ok);
    wait_sync(150, ok);
    vectors++; if (!ok || ack_cnt != 0 || bufferSel !== 1'b0) begin miscompares++; $display("FAIL reset_drops_pending ok=%0b acks=%0d sel=%0b want 1/0/0", ok, ack_cnt, bufferSel); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int s, f;
    do_reset();
    period = PW'(100); eng_delay = 2; eng_len = 40; enable = 1'b1;
    wait_sync(10, ok);
    s = last_sync; f = busy_to; req_a = s + 5;
    tick_until(s + 10);
    enable = 1'b0;
    tick_until(f + 1);
    vectors++; if (schedBusy !== 1'b1) begin miscompares++; $display("FAIL disable_frame_completes busy=%0b want 1", schedBusy); end
    tick();
    vectors++; if (schedBusy !== 1'b0 || swapAck !== 1'b1 || bufferSel !== 1'b1) begin miscompares++; $display("FAIL disable_to_idle busy=%0b ack=%0b sel=%0b want 0/1/1", schedBusy, swapAck, bufferSel); end
    tick_until(f + 200);
    vectors++; if (sync_cnt != 1) begin miscompares++; $display("FAIL disable_no_restart syncs=%0d want 1", sync_cnt); end
  endtask

  task automatic test_random();
    bit ok;
    int s, f, p, exp_next, exp_fc, do_req;
    bit exp_ovr, exp_bsel;
    do_reset();
    eng_delay = $urandom_range(4, 1); eng_len = $urandom_range(220, 10);
    period = PW'($urandom_range(200, 60)); enable = 1'b1;
    wait_sync(10, ok);
    exp_fc = 1; exp_bsel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s = last_sync; f = busy_to;
      p = $urandom_range(200, 60);
      period = PW'(p);
      do_req = $urandom_range(1, 0);
      req_a = -1; req_b = -1;
      if (do_req != 0) begin
        req_a = s + 2 + $urandom_range(f - s - 1, 0);
        if ($urandom_range(1, 0) == 1) req_b = s + 2 + $urandom_range(f - s - 1, 0);
      end
      eng_delay = $urandom_range(4, 1); eng_len = $urandom_range(220, 10);
      ack_cnt = 0;
      flagClear = 1'b1; tick(); flagClear = 1'b0;
      wait_sync(500, ok);
      exp_next = (s + p > f + 3) ? s + p : f + 3;
      exp_ovr  = (f - s + 1 >= p);
      exp_fc   = exp_fc + 1;
      if (do_req != 0) exp_bsel = ~exp_bsel;
      vectors++; if (!ok || last_sync != exp_next) begin miscompares++; $display("FAIL rand_next_sync frame %0d at %0d want %0d", i, last_sync, exp_next); end
      vectors++; if (overrun !== exp_ovr) begin miscompares++; $display("FAIL rand_overrun frame %0d got %0b want %0b", i, overrun, exp_ovr); end
      vectors++; if (ack_cnt != do_req || bufferSel !== exp_bsel) begin miscompares++; $display("FAIL rand_swap frame %0d acks=%0d sel=%0b want %0d/%0b", i, ack_cnt, bufferSel, do_req, exp_bsel); end
      vectors++; if (frameCount !== FW'(exp_fc)) begin miscompares++; $display("FAIL rand_fc frame %0d got %0d want %0d", i, frameCount, exp_fc); end
    end
    vectors++; if (bsel_violations != 0) begin miscompares++; $display("FAIL rand_swap_while_busy count=%0d want 0", bsel_violations); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_overrun();
    test_swap();
    test_oneshot();
    test_start_fault();
    test_reset_mid_frame();
    test_enable_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
